// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the IF/ID, ID/EX, EX/MEM
// and MEM/WB pipeline registers. It resolves load-use hazards and taken
// branches, and freezes the pipeline while MEM owns the shared RAM. It also
// keeps saturating statistics counters for stalls and flushes.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  idRs,
    input  logic [3:0]  idRt,
    input  logic        idUseRs,
    input  logic        idUseRt,
    input  logic        exMemRead,
    input  logic        exRegWrite,
    input  logic [3:0]  exRd,
    input  logic        exBranchTaken,
    input  logic        memAccess,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        idexWrite,
    output logic        exmemWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbFlush,
    output logic        busy,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // A MEM_WAIT of zero means memAccess never freezes the pipeline.
    localparam logic       FREEZE_EN   = (MEM_WAIT != 0);
    localparam logic [3:0] WAIT_RELOAD = 4'(MEM_WAIT) - 4'd1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic load_hit;
    logic freeze;
    logic branch;
    logic load_use;

    // Classify the current cycle; priority is freeze > branch > load-use.
    always_comb begin
        load_hit = exMemRead & exRegWrite & (exRd != 4'd0) &
                   ((idUseRs & (idRs == exRd)) | (idUseRt & (idRt == exRd)));
        freeze   = (state_q == WAIT) |
                   ((state_q == RUN) & memAccess & FREEZE_EN);
        // WAIT always freezes, so branch/load-use only ever fire in RUN or DONE.
        branch   = ~freeze & exBranchTaken;
        load_use = ~freeze & ~branch & load_hit;
    end

    // Per-stage enables and bubbles; reset forces every stage to bubble.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        busy       = (state_q != RUN);
        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            memwbFlush = 1'b1;
            busy       = 1'b0;
        end else if (freeze) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
        end else if (branch) begin
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
        end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexFlush  = 1'b1;
        end
    end

    // Next state and freeze countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    if (MEM_WAIT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_RELOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((freeze | load_use) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (branch && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (MEM_WAIT=1 and
// MEM_WAIT=3) share the stimulus. The driver pushes hand-computed expectations
// each cycle and a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  idRs, idRt, exRd;
    logic        idUseRs, idUseRt, exMemRead, exRegWrite, exBranchTaken, memAccess;

    logic        a_pc, a_ifid, a_idex, a_exmem, a_ifidF, a_idexF, a_memwbF, a_busy;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_ifidF, b_idexF, b_memwbF, b_busy;
    logic [15:0] b_stall, b_flush;

    // {pcWrite,ifidWrite,idexWrite,exmemWrite,ifidFlush,idexFlush,memwbFlush,busy}
    localparam logic [7:0] C_RST  = 8'b0000_1110;
    localparam logic [7:0] C_IDLE = 8'b1111_0000;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_FRZ  = 8'b0000_0010;
    localparam logic [7:0] C_WAIT = 8'b0000_0011;
    localparam logic [7:0] C_DONE = 8'b1111_0001;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_BRD  = 8'b1111_1101;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        bit          sel;     // 0: MEM_WAIT=1 instance, 1: MEM_WAIT=3 instance
        bit          chk_cnt;
        logic [15:0] stall;
        logic [15:0] flush;
    } sb_item_t;

    sb_item_t sb_q[$];
    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(.MEM_WAIT(1)) dut_a (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUseRs(idUseRs), .idUseRt(idUseRt),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd),
        .exBranchTaken(exBranchTaken), .memAccess(memAccess),
        .pcWrite(a_pc), .ifidWrite(a_ifid), .idexWrite(a_idex), .exmemWrite(a_exmem),
        .ifidFlush(a_ifidF), .idexFlush(a_idexF), .memwbFlush(a_memwbF), .busy(a_busy),
        .stallCount(a_stall), .flushCount(a_flush)
    );

    pipeline_hazard_ctrl #(.MEM_WAIT(3)) dut_b (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUseRs(idUseRs), .idUseRt(idUseRt),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd),
        .exBranchTaken(exBranchTaken), .memAccess(memAccess),
        .pcWrite(b_pc), .ifidWrite(b_ifid), .idexWrite(b_idex), .exmemWrite(b_exmem),
        .ifidFlush(b_ifidF), .idexFlush(b_idexF), .memwbFlush(b_memwbF), .busy(b_busy),
        .stallCount(b_stall), .flushCount(b_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expectation is consumed per cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                automatic sb_item_t it = sb_q.pop_front();
                automatic logic [7:0]  act_c;
                automatic logic [15:0] act_s, act_f;
                if (it.sel) begin
                    act_c = {b_pc, b_ifid, b_idex, b_exmem, b_ifidF, b_idexF, b_memwbF, b_busy};
                    act_s = b_stall;
                    act_f = b_flush;
                end else begin
                    act_c = {a_pc, a_ifid, a_idex, a_exmem, a_ifidF, a_idexF, a_memwbF, a_busy};
                    act_s = a_stall;
                    act_f = a_flush;
                end
                total++;
                if (act_c !== it.ctrl) begin
                    bad++;
                    $display("FAIL %s ctrl: got %b expected %b", it.name, act_c, it.ctrl);
                end
                if (it.chk_cnt) begin
                    total++;
                    if (act_s !== it.stall) begin
                        bad++;
                        $display("FAIL %s stallCount: got %h expected %h", it.name, act_s, it.stall);
                    end
                    total++;
                    if (act_f !== it.flush) begin
                        bad++;
                        $display("FAIL %s flushCount: got %h expected %h", it.name, act_f, it.flush);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                          input logic urs, input logic urt, input logic mr, input logic rw,
                          input logic [3:0] rd, input logic br, input logic ma);
        rst = r; idRs = rs; idRt = rt; idUseRs = urs; idUseRt = urt;
        exMemRead = mr; exRegWrite = rw; exRd = rd; exBranchTaken = br; memAccess = ma;
    endtask

    task automatic expect_c(input string nm, input logic [7:0] c, input bit sel,
                            input bit cc, input logic [15:0] s, input logic [15:0] f);
        sb_item_t it;
        it.name = nm; it.ctrl = c; it.sel = sel; it.chk_cnt = cc; it.stall = s; it.flush = f;
        sb_q.push_back(it);
    endtask

    task automatic idle();
        set_in(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
    endtask

    task automatic do_reset();
        tick(); set_in(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        expect_c("rst_a", C_RST, 0, 0, 16'd0, 16'd0);
        tick();
        expect_c("rst_b", C_RST, 1, 1, 16'd0, 16'd0);
        tick(); idle();
        expect_c("rel_a", C_IDLE, 0, 1, 16'd0, 16'd0);
    endtask

    initial begin
        set_in(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);

        // Reset and release
        tick(); expect_c("rst1", C_RST, 0, 0, 16'd0, 16'd0);
        tick(); expect_c("rst2", C_RST, 0, 1, 16'd0, 16'd0);
        tick(); idle(); expect_c("release", C_IDLE, 0, 1, 16'd0, 16'd0);

        // Load-use on Rs, then non-hazard variants, then Rt path
        tick(); set_in(0, 4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0);
        expect_c("lu_rs", C_LU, 0, 1, 16'd0, 16'd0);
        tick(); idle(); expect_c("lu_after", C_IDLE, 0, 1, 16'd1, 16'd0);
        tick(); set_in(0, 4'd0, 4'd0, 1, 0, 1, 1, 4'd0, 0, 0);
        expect_c("rd_zero", C_IDLE, 0, 1, 16'd1, 16'd0);
        tick(); set_in(0, 4'd3, 4'd0, 0, 0, 1, 1, 4'd3, 0, 0);
        expect_c("no_use", C_IDLE, 1, 1, 16'd1, 16'd0);
        tick(); set_in(0, 4'd3, 4'd3, 1, 1, 0, 1, 4'd3, 0, 0);
        expect_c("not_load", C_IDLE, 0, 1, 16'd1, 16'd0);
        tick(); set_in(0, 4'd5, 4'd3, 0, 1, 1, 1, 4'd3, 0, 0);
        expect_c("lu_rt", C_LU, 0, 1, 16'd1, 16'd0);
        tick(); idle(); expect_c("lu_rt_after", C_IDLE, 1, 1, 16'd2, 16'd0);

        // MEM_WAIT=3 freeze sequence with memAccess held high
        do_reset();
        tick(); set_in(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1);
        expect_c("frz3_c1", C_FRZ, 1, 1, 16'd0, 16'd0);
        tick(); expect_c("frz3_c2", C_WAIT, 1, 1, 16'd1, 16'd0);
        tick(); expect_c("frz3_c3", C_WAIT, 1, 1, 16'd2, 16'd0);
        tick(); expect_c("frz3_done", C_DONE, 1, 1, 16'd3, 16'd0);
        tick(); idle(); expect_c("frz3_run", C_IDLE, 1, 1, 16'd3, 16'd0);

        // MEM_WAIT=1: branch coinciding with memAccess is applied in DONE
        do_reset();
        tick(); set_in(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 1);
        expect_c("brfrz_c1", C_FRZ, 0, 1, 16'd0, 16'd0);
        tick(); expect_c("brfrz_done", C_BRD, 0, 1, 16'd1, 16'd0);
        tick(); idle(); expect_c("brfrz_after", C_IDLE, 0, 1, 16'd1, 16'd1);
        // Branch suppresses a simultaneous load-use
        tick(); set_in(0, 4'd7, 4'd0, 1, 0, 1, 1, 4'd7, 1, 0);
        expect_c("br_over_lu", C_BR, 0, 1, 16'd1, 16'd1);
        tick(); idle(); expect_c("br_over_lu_after", C_IDLE, 0, 1, 16'd1, 16'd2);

        // Reset in the middle of WAIT goes straight to RUN
        do_reset();
        tick(); set_in(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1);
        expect_c("mid_c1", C_FRZ, 1, 1, 16'd0, 16'd0);
        tick(); expect_c("mid_wait", C_WAIT, 1, 1, 16'd1, 16'd0);
        tick(); set_in(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1);
        expect_c("mid_rst", C_RST, 1, 1, 16'd2, 16'd0);
        tick(); idle(); expect_c("mid_run", C_IDLE, 1, 1, 16'd0, 16'd0);
        tick(); expect_c("mid_no_done", C_IDLE, 1, 1, 16'd0, 16'd0);

        // Saturation: hold a load-use hazard continuously
        do_reset();
        tick(); set_in(0, 4'd2, 4'd0, 1, 0, 1, 1, 4'd2, 0, 0);
        repeat (65533) tick();
        tick(); expect_c("sat_fffe", C_LU, 0, 1, 16'hFFFE, 16'd0);
        tick(); expect_c("sat_ffff", C_LU, 1, 1, 16'hFFFF, 16'd0);
        tick(); expect_c("sat_hold", C_LU, 0, 1, 16'hFFFF, 16'd0);
        tick(); idle(); expect_c("sat_idle", C_IDLE, 0, 1, 16'hFFFF, 16'd0);
        tick(); expect_c("sat_idle2", C_IDLE, 1, 1, 16'hFFFF, 16'd0);

        tick(); tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
